// File: rtl/text_console_ctrl.sv
// text_console_ctrl
//   Turns a stream of character/control commands into single-cell writes on the
//   character-cell display buffer. It keeps a text cursor and performs row
//   clears and full-screen clears.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : command handshake (accept = in_valid & in_ready)
//   in_cmd              : 0 PRINT, 1 NEWLINE, 2 BACKSPACE, 3 CLEAR
//   in_data             : character code for PRINT
//   w_h_addr/w_v_addr   : registered buffer column/row address
//   w_data, w_en        : registered buffer write data and strobe
//   cur_x, cur_y        : cursor position
//   busy                : high while a row clear or screen clear is running
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 60,
  parameter logic [5:0] BLANK = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_cmd,
  input  logic [5:0] in_data,
  output logic       in_ready,
  output logic [7:0] w_h_addr,
  output logic [7:0] w_v_addr,
  output logic [5:0] w_data,
  output logic       w_en,
  output logic [7:0] cur_x,
  output logic [7:0] cur_y,
  output logic       busy
);

  localparam logic [7:0] COLS_M1 = 8'(COLS - 1);
  localparam logic [7:0] ROWS_M1 = 8'(ROWS - 1);

  localparam logic [1:0] CMD_PRINT     = 2'd0;
  localparam logic [1:0] CMD_NEWLINE   = 2'd1;
  localparam logic [1:0] CMD_BACKSPACE = 2'd2;
  localparam logic [1:0] CMD_CLEAR     = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ROWCLR = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] sx_reg, sx_next;      // sweep column (screen clear and row clear)
  logic [7:0] sy_reg, sy_next;      // sweep row (screen clear only)
  logic [7:0] cx_reg, cx_next;
  logic [7:0] cy_reg, cy_next;
  logic [7:0] wh_reg, wh_next;
  logic [7:0] wv_reg, wv_next;
  logic [5:0] wd_reg, wd_next;
  logic       wen_reg, wen_next;

  logic       accept;
  logic       sweep_row_end;
  logic       sweep_last;
  logic       cur_row_end;
  logic [7:0] cy_inc;

  assign accept        = in_valid && (state_reg == ST_IDLE);
  assign sweep_row_end = (sx_reg == COLS_M1);
  assign sweep_last    = sweep_row_end && (sy_reg == ROWS_M1);
  assign cur_row_end   = (cx_reg == COLS_M1);
  // Next row with explicit wrap; the bottom row is followed by row 0.
  assign cy_inc        = (cy_reg == ROWS_M1) ? 8'd0 : cy_reg + 8'd1;

  // State and datapath register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      sx_reg    <= 8'd0;
      sy_reg    <= 8'd0;
      cx_reg    <= 8'd0;
      cy_reg    <= 8'd0;
      wh_reg    <= 8'd0;
      wv_reg    <= 8'd0;
      wd_reg    <= 6'd0;
      wen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sx_reg    <= sx_next;
      sy_reg    <= sy_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      wh_reg    <= wh_next;
      wv_reg    <= wv_next;
      wd_reg    <= wd_next;
      wen_reg   <= wen_next;
    end
  end

  // Next-state logic. Leaving a clear happens on the same edge that registers
  // its final write, so in_ready is already high during that write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR:  if (sweep_last)    state_next = ST_IDLE;
      ST_ROWCLR: if (sweep_row_end) state_next = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          case (in_cmd)
            CMD_PRINT:   if (cur_row_end) state_next = ST_ROWCLR;
            CMD_NEWLINE: state_next = ST_ROWCLR;
            CMD_CLEAR:   state_next = ST_CLEAR;
            default:     state_next = ST_IDLE;
          endcase
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Write-port and cursor next values
  always_comb begin
    sx_next  = sx_reg;
    sy_next  = sy_reg;
    cx_next  = cx_reg;
    cy_next  = cy_reg;
    wh_next  = wh_reg;
    wv_next  = wv_reg;
    wd_next  = wd_reg;
    wen_next = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        wen_next = 1'b1;
        wh_next  = sx_reg;
        wv_next  = sy_reg;
        wd_next  = BLANK;
        if (sweep_row_end) begin
          sx_next = 8'd0;
          sy_next = (sy_reg == ROWS_M1) ? 8'd0 : sy_reg + 8'd1;
        end else begin
          sx_next = sx_reg + 8'd1;
        end
      end
      ST_ROWCLR: begin
        wen_next = 1'b1;
        wh_next  = sx_reg;
        wv_next  = cy_reg;
        wd_next  = BLANK;
        sx_next  = sweep_row_end ? 8'd0 : sx_reg + 8'd1;
      end
      ST_IDLE: begin
        if (accept) begin
          case (in_cmd)
            CMD_PRINT: begin
              wen_next = 1'b1;
              wh_next  = cx_reg;
              wv_next  = cy_reg;
              wd_next  = in_data;
              if (cur_row_end) begin
                cx_next = 8'd0;
                cy_next = cy_inc;
                sx_next = 8'd0;
              end else begin
                cx_next = cx_reg + 8'd1;
              end
            end
            CMD_NEWLINE: begin
              cx_next = 8'd0;
              cy_next = cy_inc;
              sx_next = 8'd0;
            end
            CMD_BACKSPACE: begin
              if (cx_reg != 8'd0) begin
                cx_next  = cx_reg - 8'd1;
                wen_next = 1'b1;
                wh_next  = cx_reg - 8'd1;
                wv_next  = cy_reg;
                wd_next  = BLANK;
              end else if (cy_reg != 8'd0) begin
                cx_next  = COLS_M1;
                cy_next  = cy_reg - 8'd1;
                wen_next = 1'b1;
                wh_next  = COLS_M1;
                wv_next  = cy_reg - 8'd1;
                wd_next  = BLANK;
              end
            end
            default: begin // CMD_CLEAR: cursor homes, sweep restarts
              cx_next = 8'd0;
              cy_next = 8'd0;
              sx_next = 8'd0;
              sy_next = 8'd0;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign in_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);
  assign w_h_addr = wh_reg;
  assign w_v_addr = wv_reg;
  assign w_data   = wd_reg;
  assign w_en     = wen_reg;
  assign cur_x    = cx_reg;
  assign cur_y    = cy_reg;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed testbench for text_console_ctrl with default geometry (80x60).
module tb_text_console_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_cmd;
  logic [5:0] in_data;
  logic       in_ready;
  logic [7:0] w_h_addr;
  logic [7:0] w_v_addr;
  logic [5:0] w_data;
  logic       w_en;
  logic [7:0] cur_x;
  logic [7:0] cur_y;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(6'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_cmd   (in_cmd),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w_h_addr (w_h_addr),
    .w_v_addr (w_v_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [5:0] d);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Follow a run of consecutive writes until w_en drops. full=1: screen sweep
  // in row-major order; full=0: clear of the given row.
  task automatic run_sweep(input string tag, input int exp_n, input bit full, input int row);
    int  n, aerr, rerr, ex, ey;
    bit  done;
    n = 0; aerr = 0; rerr = 0; done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      tick();
      if (!w_en) begin
        done = 1'b1;
      end else begin
        ex = full ? (n % COLS) : n;
        ey = full ? (n / COLS) : row;
        if (int'(w_h_addr) != ex || int'(w_v_addr) != ey || w_data != 6'd0) aerr++;
        if (in_ready != (n == exp_n - 1) || busy == in_ready) rerr++;
        n++;
      end
    end
    check({tag, " terminated"}, 32'(done), 32'd1);
    check({tag, " write count"}, 32'(n), 32'(exp_n));
    check({tag, " addr/data errors"}, 32'(aerr), 32'd0);
    check({tag, " ready/busy errors"}, 32'(rerr), 32'd0);
  endtask

  task automatic newlines(input int k, input int start_row);
    for (int i = 0; i < k; i++) begin
      send(2'd1, 6'd0);
      run_sweep("newline rowclr", COLS, 1'b0, (start_row + i + 1) % ROWS);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cmd = 2'd0; in_data = 6'd0;
    tick(); tick(); tick();
    check("reset w_en", 32'(w_en), 32'd0);
    check("reset w_h_addr", 32'(w_h_addr), 32'd0);
    check("reset w_v_addr", 32'(w_v_addr), 32'd0);
    check("reset w_data", 32'(w_data), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset cursor", {16'd0, cur_y, cur_x}, 32'd0);

    // Power-up sweep
    rst = 1'b0;
    run_sweep("reset sweep", COLS * ROWS, 1'b1, 0);
    check("post sweep cursor", {16'd0, cur_y, cur_x}, 32'd0);
    check("post sweep in_ready", 32'(in_ready), 32'd1);

    // Back-to-back PRINT 1,2,3
    in_valid = 1'b1; in_cmd = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = 6'(i + 1);
      tick();
      check("b2b w_en", 32'(w_en), 32'd1);
      check("b2b addr", {16'd0, w_v_addr, w_h_addr}, 32'(i));
      check("b2b data", 32'(w_data), 32'(i + 1));
      check("b2b in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    check("b2b cursor x", 32'(cur_x), 32'd3);
    check("b2b cursor y", 32'(cur_y), 32'd0);
    tick();
    check("idle w_en low", 32'(w_en), 32'd0);
    check("idle w_data held", 32'(w_data), 32'd3);

    // Move to (79,5): five newlines then 79 prints
    newlines(5, 0);
    check("after newlines cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd5, 8'd0});
    in_valid = 1'b1; in_cmd = 2'd0; in_data = 6'd9;
    for (int i = 0; i < COLS - 1; i++) tick();
    in_valid = 1'b0;
    check("fill row cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd5, 8'd79});

    // Row-ending PRINT
    send(2'd0, 6'd7);
    check("rowend w_en", 32'(w_en), 32'd1);
    check("rowend addr", {16'd0, w_v_addr, w_h_addr}, {16'd0, 8'd5, 8'd79});
    check("rowend data", 32'(w_data), 32'd7);
    check("rowend in_ready", 32'(in_ready), 32'd0);
    check("rowend cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd6, 8'd0});
    run_sweep("rowend rowclr", COLS, 1'b0, 6);

    // Wrap at bottom: get to (10,59) then NEWLINE
    newlines(53, 6);
    in_valid = 1'b1; in_cmd = 2'd0; in_data = 6'd4;
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    check("bottom cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd59, 8'd10});
    send(2'd1, 6'd0);
    check("wrap accept w_en", 32'(w_en), 32'd0);
    check("wrap cursor", {16'd0, cur_y, cur_x}, 32'd0);
    run_sweep("wrap rowclr", COLS, 1'b0, 0);

    // BACKSPACE at (0,0)
    send(2'd2, 6'd0);
    check("bs origin w_en", 32'(w_en), 32'd0);
    check("bs origin cursor", {16'd0, cur_y, cur_x}, 32'd0);

    // BACKSPACE at (0,3)
    newlines(3, 0);
    send(2'd2, 6'd0);
    check("bs row w_en", 32'(w_en), 32'd1);
    check("bs row addr", {16'd0, w_v_addr, w_h_addr}, {16'd0, 8'd2, 8'd79});
    check("bs row data", 32'(w_data), 32'd0);
    check("bs row cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd2, 8'd79});
    check("bs row in_ready", 32'(in_ready), 32'd1);
    send(2'd2, 6'd0);
    check("bs mid addr", {16'd0, w_v_addr, w_h_addr}, {16'd0, 8'd2, 8'd78});
    check("bs mid cursor", {16'd0, cur_y, cur_x}, {16'd0, 8'd2, 8'd78});

    // CLEAR command interrupted by reset after 100 writes
    send(2'd3, 6'd0);
    check("clear accept w_en", 32'(w_en), 32'd0);
    check("clear accept busy", 32'(busy), 32'd1);
    check("clear cursor home", {16'd0, cur_y, cur_x}, 32'd0);
    begin
      int nw;
      nw = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (w_en) nw++;
      end
      check("mid clear writes", 32'(nw), 32'd100);
      check("mid clear last addr", {16'd0, w_v_addr, w_h_addr}, {16'd0, 8'd1, 8'd19});
    end
    rst = 1'b1;
    tick();
    check("mid reset w_en", 32'(w_en), 32'd0);
    check("mid reset addr", {16'd0, w_v_addr, w_h_addr}, 32'd0);
    rst = 1'b0;
    run_sweep("restart sweep", COLS * ROWS, 1'b1, 0);
    check("restart cursor", {16'd0, cur_y, cur_x}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
